red_pitaya_dfilt_ctrl: RTL and testbench



---
 rtl/red_pitaya_dfilt_pkg.sv | 37 +++
 rtl/red_pitaya_dfilt_settle_cnt.sv | 36 +++
 rtl/red_pitaya_dfilt_ctrl.sv | 156 +++++++++++++++
 tb/tb_red_pitaya_dfilt_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_dfilt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_dfilt_pkg
// Description : Shared constants for the equalization-filter coefficient
//               sequencer: register map, field widths, coefficient defaults
//               and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package red_pitaya_dfilt_pkg;

    localparam int AA_W = 18;
    localparam int CF_W = 25;

    localparam logic [2:0] ADDR_AA     = 3'd0;
    localparam logic [2:0] ADDR_BB     = 3'd1;
    localparam logic [2:0] ADDR_KK     = 3'd2;
    localparam logic [2:0] ADDR_PP     = 3'd3;
    localparam logic [2:0] ADDR_SETTLE = 3'd4;
    localparam logic [2:0] ADDR_FLUSH  = 3'd5;

    localparam logic [AA_W-1:0] AA_DEF   = '0;
    localparam logic [CF_W-1:0] BB_DEF   = '0;
    localparam logic [CF_W-1:0] KK_DEF_C = 25'h0FFFFFF;
    localparam logic [CF_W-1:0] PP_DEF   = '0;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        APPLY  = ST_APPLY,
        SETTLE = ST_SETTLE
    } state_e;

endpackage
`default_nettype wire

// File: rtl/red_pitaya_dfilt_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_dfilt_settle_cnt
// Description : Loadable down-counter. term_o flags the last decrementing
//               cycle (count at 1 while dec_i is high).
// Ports       : clk_i, rst_i (async, active high), load_i/load_val_i,
//               dec_i, term_o
// Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_dfilt_settle_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign term_o = dec_i && (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/red_pitaya_dfilt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_dfilt_ctrl
// Description : Coefficient sequencer and output guard for the equalization
//               filter. Bus writes go to shadow registers; a commit copies
//               them atomically to the active set, optionally pulses the
//               filter reset, and blanks the output for a settle time.
// Ports       : adc_clk_i/adc_rst_i        clock, async active-high reset
//               wr_stb_i/wr_addr_i/wr_data_i  shadow register writes
//               commit_i                     apply shadow set
//               flt_dat_i                    filter output sample
//               cfg_{aa,bb,kk,pp}_o          active coefficients
//               flt_rstn_o                   filter reset (active low)
//               adc_dat_o                    guarded sample
//               busy_o / settled_o           status
// Option      : RED_PITAYA_DFILT_CTRL_RAW_EN adds adc_raw_i, passed through
//               while blanked instead of holding the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_dfilt_ctrl
    import red_pitaya_dfilt_pkg::*;
#(
    parameter int              CNT_W      = 16,
    parameter int              SETTLE_DEF = 64,
    parameter logic [CF_W-1:0] KK_DEF     = KK_DEF_C
) (
    input  logic            adc_clk_i,
    input  logic            adc_rst_i,
    input  logic            wr_stb_i,
    input  logic [2:0]      wr_addr_i,
    input  logic [CF_W-1:0] wr_data_i,
    input  logic            commit_i,
    input  logic [13:0]     flt_dat_i,
`ifdef RED_PITAYA_DFILT_CTRL_RAW_EN
    input  logic [13:0]     adc_raw_i,
`endif
    output logic [AA_W-1:0] cfg_aa_o,
    output logic [CF_W-1:0] cfg_bb_o,
    output logic [CF_W-1:0] cfg_kk_o,
    output logic [CF_W-1:0] cfg_pp_o,
    output logic            flt_rstn_o,
    output logic [13:0]     adc_dat_o,
    output logic            busy_o,
    output logic            settled_o
);

    state_e           state_q, state_d;
    logic [AA_W-1:0]  aa_sh_q, aa_q;
    logic [CF_W-1:0]  bb_sh_q, bb_q, kk_sh_q, kk_q, pp_sh_q, pp_q;
    logic [CNT_W-1:0] settle_q;
    logic             flush_q, flush_d;
    logic             flt_rstn_q, busy_q, settled_q;
    logic [13:0]      adc_q;
    logic             cnt_term;

    red_pitaya_dfilt_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
        .clk_i      (adc_clk_i),
        .rst_i      (adc_rst_i),
        .load_i     (state_q == APPLY),
        .load_val_i (settle_q),
        .dec_i      (state_q == SETTLE),
        .term_o     (cnt_term)
    );

    // A flush write in the commit cycle must already govern the APPLY pulse.
    always_comb begin
        flush_d = flush_q;
        if (wr_stb_i && (wr_addr_i == ADDR_FLUSH)) begin
            flush_d = wr_data_i[0];
        end
    end

    // Commit outranks settle completion; commits during APPLY are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (commit_i) state_d = APPLY;
            APPLY:   state_d = (settle_q != '0) ? SETTLE : RUN;
            SETTLE: begin
                if (commit_i)      state_d = APPLY;
                else if (cnt_term) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            aa_sh_q  <= AA_DEF;
            bb_sh_q  <= BB_DEF;
            kk_sh_q  <= KK_DEF;
            pp_sh_q  <= PP_DEF;
            settle_q <= CNT_W'(SETTLE_DEF);
            flush_q  <= 1'b0;
        end else begin
            flush_q <= flush_d;
            if (wr_stb_i) begin
                case (wr_addr_i)
                    ADDR_AA:     aa_sh_q  <= wr_data_i[AA_W-1:0];
                    ADDR_BB:     bb_sh_q  <= wr_data_i;
                    ADDR_KK:     kk_sh_q  <= wr_data_i;
                    ADDR_PP:     pp_sh_q  <= wr_data_i;
                    ADDR_SETTLE: settle_q <= wr_data_i[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            state_q    <= RUN;
            aa_q       <= AA_DEF;
            bb_q       <= BB_DEF;
            kk_q       <= KK_DEF;
            pp_q       <= PP_DEF;
            flt_rstn_q <= 1'b1;
            busy_q     <= 1'b0;
            settled_q  <= 1'b0;
            adc_q      <= '0;
        end else begin
            state_q <= state_d;
            // Active set takes the shadow as it stood during APPLY.
            if (state_q == APPLY) begin
                aa_q <= aa_sh_q;
                bb_q <= bb_sh_q;
                kk_q <= kk_sh_q;
                pp_q <= pp_sh_q;
            end
            // Status flags are computed from the next state so they line
            // up with the state register.
            flt_rstn_q <= ~((state_d == APPLY) && flush_d);
            busy_q     <= (state_d != RUN);
            settled_q  <= (state_d == RUN) && (state_q != RUN);
            if (state_q == RUN) begin
                adc_q <= flt_dat_i;
            end
`ifdef RED_PITAYA_DFILT_CTRL_RAW_EN
            else begin
                adc_q <= adc_raw_i;
            end
`endif
        end
    end

    assign cfg_aa_o   = aa_q;
    assign cfg_bb_o   = bb_q;
    assign cfg_kk_o   = kk_q;
    assign cfg_pp_o   = pp_q;
    assign flt_rstn_o = flt_rstn_q;
    assign adc_dat_o  = adc_q;
    assign busy_o     = busy_q;
    assign settled_o  = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_dfilt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_red_pitaya_dfilt_ctrl
// Description : Self-checking bench for red_pitaya_dfilt_ctrl. A reference
//               model tracks "remaining blanked cycles" and compares every
//               output each cycle; directed scenarios add cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_dfilt_ctrl;

    localparam logic [24:0] KK_RST = 25'h0FFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_stb = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [24:0] wr_data = '0;
    logic        commit = 1'b0;
    logic [13:0] flt_dat = '0;
`ifdef RED_PITAYA_DFILT_CTRL_RAW_EN
    logic [13:0] adc_raw = '0;
`endif
    logic [17:0] cfg_aa;
    logic [24:0] cfg_bb, cfg_kk, cfg_pp;
    logic        flt_rstn, busy, settled;
    logic [13:0] adc_dat;

    red_pitaya_dfilt_ctrl dut (
        .adc_clk_i  (clk),
        .adc_rst_i  (rst),
        .wr_stb_i   (wr_stb),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .commit_i   (commit),
        .flt_dat_i  (flt_dat),
`ifdef RED_PITAYA_DFILT_CTRL_RAW_EN
        .adc_raw_i  (adc_raw),
`endif
        .cfg_aa_o   (cfg_aa),
        .cfg_bb_o   (cfg_bb),
        .cfg_kk_o   (cfg_kk),
        .cfg_pp_o   (cfg_pp),
        .flt_rstn_o (flt_rstn),
        .adc_dat_o  (adc_dat),
        .busy_o     (busy),
        .settled_o  (settled)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: shadow/active arrays (0=AA,1=BB,2=KK,3=PP), the
    // configured settle time, and the number of settle cycles still owed.
    logic [24:0] m_sh[4];
    logic [24:0] m_act[4];
    int          m_settle;
    bit          m_flush;
    bit          m_ap;
    int          m_rem;
    bit          m_busy, m_settled, m_rstn;
    logic [13:0] m_adc;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = (i == 2) ? KK_RST : 25'd0;
            m_act[i] = m_sh[i];
        end
        m_settle = 64; m_flush = 0; m_ap = 0; m_rem = 0;
        m_busy = 0; m_settled = 0; m_rstn = 1; m_adc = '0;
    endtask

    task automatic m_step();
        logic [24:0] old_sh[4];
        int  old_settle, nrem;
        bit  was_busy, nap;
        old_sh     = m_sh;
        old_settle = m_settle;
        was_busy   = m_ap || (m_rem > 0);
        if (wr_stb) begin
            case (wr_addr)
                3'd0: m_sh[0] = {7'd0, wr_data[17:0]};
                3'd1, 3'd2, 3'd3: m_sh[wr_addr] = wr_data;
                3'd4: m_settle = int'(wr_data[15:0]);
                3'd5: m_flush = wr_data[0];
                default: ;
            endcase
        end
        if (m_ap) m_act = old_sh;
        if (!was_busy) m_adc = flt_dat;
`ifdef RED_PITAYA_DFILT_CTRL_RAW_EN
        else m_adc = adc_raw;
`endif
        if (m_ap) begin
            nap = 0; nrem = old_settle;
        end else if (commit) begin
            nap = 1; nrem = 0;
        end else begin
            nap = 0; nrem = (m_rem > 0) ? m_rem - 1 : 0;
        end
        m_settled = was_busy && !nap && (nrem == 0);
        m_busy    = nap || (nrem > 0);
        m_rstn    = !(nap && m_flush);
        m_ap  = nap;
        m_rem = nrem;
    endtask

    task automatic compare_all();
        check("cfg_aa",   32'(cfg_aa),   32'(m_act[0][17:0]));
        check("cfg_bb",   32'(cfg_bb),   32'(m_act[1]));
        check("cfg_kk",   32'(cfg_kk),   32'(m_act[2]));
        check("cfg_pp",   32'(cfg_pp),   32'(m_act[3]));
        check("flt_rstn", 32'(flt_rstn), 32'(m_rstn));
        check("adc_dat",  32'(adc_dat),  32'(m_adc));
        check("busy",     32'(busy),     32'(m_busy));
        check("settled",  32'(settled),  32'(m_settled));
    endtask

    task automatic step();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
    endtask

    task automatic write(input logic [2:0] a, input logic [24:0] d);
        wr_stb = 1; wr_addr = a; wr_data = d;
        step();
        wr_stb = 0;
    endtask

    // Steps until busy drops (bounded), tallying status observations.
    task automatic run_out(input int max, inout int nb, inout int ns, inout int nl);
        int k;
        k = 0;
        while (busy && k < max) begin
            step();
            if (busy) nb++;
            if (settled) ns++;
            if (!flt_rstn) nl++;
            k++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
    endtask

    int nb, ns, nl;

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        compare_all();
        check("rst_kk",   32'(cfg_kk),   32'(KK_RST));
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_rstn", 32'(flt_rstn), 32'd1);

        // Pass-through in RUN
        flt_dat = 14'h0123;
        step();
        check("run_adc", 32'(adc_dat), 32'h0123);

        // Shadow write without commit, then commit with default settle 64
        write(3'd0, 25'h001F000);
        step(); step();
        check("aa_no_commit", 32'(cfg_aa), 32'd0);
        commit = 1; flt_dat = 14'h0456;
        step();
        commit = 0; flt_dat = 14'h0789;
        nb = busy ? 1 : 0; ns = 0; nl = 0;
        step();
        if (busy) nb++;
        check("aa_applied", 32'(cfg_aa), 32'h1F000);
        run_out(200, nb, ns, nl);
        check("busy_len_64", 32'(nb), 32'd65);
        check("settled_cnt_64", 32'(ns), 32'd1);
        step();
        check("adc_resume", 32'(adc_dat), 32'h0789);

        // Flush pulse with zero settle time
        write(3'd4, 25'd0);
        write(3'd5, 25'd1);
        commit = 1;
        step();
        commit = 0;
        nb = busy ? 1 : 0; ns = 0; nl = flt_rstn ? 0 : 1;
        run_out(20, nb, ns, nl);
        check("flush_low_len", 32'(nl), 32'd1);
        check("settle0_busy", 32'(nb), 32'd1);
        check("settle0_settled", 32'(ns), 32'd1);
        write(3'd5, 25'd0);
        commit = 1;
        step();
        commit = 0;
        nb = busy ? 1 : 0; ns = 0; nl = flt_rstn ? 0 : 1;
        run_out(20, nb, ns, nl);
        check("noflush_low", 32'(nl), 32'd0);

        // Recommit during SETTLE with a new BB
        write(3'd4, 25'd10);
        commit = 1;
        step();
        commit = 0;
        nb = busy ? 1 : 0; ns = 0; nl = 0;
        for (int i = 0; i < 4; i++) begin
            wr_stb = (i == 1); wr_addr = 3'd1; wr_data = 25'h0ABCDEF;
            step();
            if (busy) nb++;
            if (settled) ns++;
        end
        wr_stb = 0;
        commit = 1;
        step();
        commit = 0;
        if (busy) nb++;
        run_out(50, nb, ns, nl);
        check("recommit_busy", 32'(nb), 32'd16);
        check("recommit_settled", 32'(ns), 32'd1);
        check("recommit_bb", 32'(cfg_bb), 32'h0ABCDEF);

        // Asynchronous reset in the middle of SETTLE
        commit = 1;
        step();
        commit = 0;
        step(); step();
        #2;
        rst = 1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bb",   32'(cfg_bb), 32'd0);
        check("arst_kk",   32'(cfg_kk), 32'(KK_RST));
        check("arst_adc",  32'(adc_dat), 32'd0);
        check("arst_settled", 32'(settled), 32'd0);
        m_reset();
        #2;
        rst = 0;
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            wr_stb  = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = (wr_addr == 3'd4) ? 25'($urandom_range(0, 12)) : 25'($urandom);
            commit  = ($urandom_range(0, 11) == 0);
            flt_dat = 14'($urandom);
`ifdef RED_PITAYA_DFILT_CTRL_RAW_EN
            adc_raw = 14'($urandom);
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
